// File: rtl/player_pkg.sv
// Shared state encoding and action-index boundaries for the per-player sequencer.
package player_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WALK,
    JUMP,
    ATTACK,
    HURT
  } action_state_t;

  localparam logic [8:0] WALK_LAST  = 9'd23;
  localparam logic [8:0] JUMP_FIRST = 9'd24;
  localparam logic [8:0] RISE_LAST  = 9'd45;
  localparam logic [8:0] FALL_FIRST = 9'd68;
  localparam logic [8:0] JUMP_LAST  = 9'd89;
  localparam logic [8:0] ATK_FIRST  = 9'd90;
  localparam logic [8:0] SUMMON_AT  = 9'd149;
  localparam logic [8:0] ATK_LAST   = 9'd185;
  localparam logic [8:0] HURT_FIRST = 9'd186;
  localparam logic [8:0] HURT_LAST  = 9'd209;

endpackage

// File: rtl/player_motion.sv
// Horizontal position and jump-height integrator; the FSM supplies per-tick strobes.
module player_motion #(
  parameter int X_INIT    = 100,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 560,
  parameter int GROUND_Y  = 300,
  parameter int WALK_STEP = 2,
  parameter int JUMP_STEP = 3
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       step_en_i,
  input  logic       left_i,
  input  logic       rise_en_i,
  input  logic       fall_en_i,
  output logic [9:0] x_o,
  output logic [9:0] y_o
);

  localparam logic [10:0] XMIN_W   = 11'(X_MIN);
  localparam logic [10:0] XMAX_W   = 11'(X_MAX);
  localparam logic [10:0] STEP_W   = 11'(WALK_STEP);
  localparam logic [9:0]  XINIT_W  = 10'(X_INIT);
  localparam logic [9:0]  JSTEP_W  = 10'(JUMP_STEP);
  localparam logic [9:0]  GROUND_W = 10'(GROUND_Y);

  logic [9:0]  x_q, x_d;
  logic [9:0]  height_q, height_d;
  logic [9:0]  y_q;
  logic [10:0] x_ext, x_sum, x_dif;

  // One extra bit keeps the step from wrapping before the clamp compares.
  assign x_ext = {1'b0, x_q};
  assign x_sum = x_ext + STEP_W;
  assign x_dif = x_ext - STEP_W;

  always_comb begin
    x_d = x_q;
    if (step_en_i) begin
      if (left_i) begin
        x_d = (x_ext < XMIN_W + STEP_W) ? XMIN_W[9:0] : x_dif[9:0];
      end else begin
        x_d = (x_sum > XMAX_W) ? XMAX_W[9:0] : x_sum[9:0];
      end
    end
  end

  always_comb begin
    height_d = height_q;
    if (rise_en_i) begin
      height_d = height_q + JSTEP_W;
    end else if (fall_en_i) begin
      height_d = (height_q < JSTEP_W) ? 10'd0 : height_q - JSTEP_W;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      x_q      <= XINIT_W;
      height_q <= '0;
      y_q      <= GROUND_W;
    end else begin
      x_q      <= x_d;
      height_q <= height_d;
      y_q      <= GROUND_W - height_d;
    end
  end

  assign x_o = x_q;
  assign y_o = y_q;

endmodule

// File: rtl/player_action_fsm.sv
// Per-player animation/motion sequencer: advances once per frame tick and
// raises a one-cycle projectile request at the attack release frame.
module player_action_fsm
  import player_pkg::*;
#(
  parameter int X_INIT    = 100,
  parameter int FACE_INIT = 0,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 560,
  parameter int GROUND_Y  = 300,
  parameter int WALK_STEP = 2,
  parameter int JUMP_STEP = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_jump,
  input  logic       key_attack,
  input  logic       hit,
  input  logic       freeze,
  output logic [8:0] player_action,
  output logic       face,
  output logic [9:0] player_x,
  output logic [9:0] player_y,
  output logic       summon_ball,
  output logic       ball_face,
  output logic       busy
);

  action_state_t state_q, state_d;
  logic [8:0]    action_q, action_d;
  logic          face_q, face_d;
  logic          hit_pending_q;
  logic          summon_q, ball_face_q, busy_q, busy_d;
  logic          tick, hit_now, one_dir;
  logic          move_en, rise_en, fall_en, summon_fire;

  assign tick    = frame_tick & ~freeze;
  assign hit_now = hit_pending_q | hit;
  assign one_dir = key_left ^ key_right;

  always_comb begin
    state_d  = state_q;
    action_d = action_q;
    if (hit_now) begin
      state_d  = HURT;
      action_d = HURT_FIRST;
    end else begin
      unique case (state_q)
        IDLE, WALK: begin
          if (key_attack) begin
            state_d  = ATTACK;
            action_d = ATK_FIRST;
          end else if (key_jump) begin
            state_d  = JUMP;
            action_d = JUMP_FIRST;
          end else if (one_dir) begin
            state_d  = WALK;
            action_d = (state_q == WALK && action_q != WALK_LAST) ? action_q + 9'd1 : 9'd0;
          end else begin
            state_d  = IDLE;
            action_d = 9'd0;
          end
        end
        JUMP: begin
          state_d  = (action_q == JUMP_LAST) ? IDLE : JUMP;
          action_d = (action_q == JUMP_LAST) ? 9'd0 : action_q + 9'd1;
        end
        ATTACK: begin
          state_d  = (action_q == ATK_LAST) ? IDLE : ATTACK;
          action_d = (action_q == ATK_LAST) ? 9'd0 : action_q + 9'd1;
        end
        HURT: begin
          state_d  = (action_q == HURT_LAST) ? IDLE : HURT;
          action_d = (action_q == HURT_LAST) ? 9'd0 : action_q + 9'd1;
        end
        default: begin
          state_d  = IDLE;
          action_d = 9'd0;
        end
      endcase
    end
  end

  // Walking moves on the tick that enters WALK; airborne drift uses the keys held mid-jump.
  assign move_en = tick & one_dir &
                   ((state_d == WALK) | ((state_q == JUMP) & ~hit_now));
  assign rise_en = tick & ~hit_now & (state_q == JUMP) & (action_q <= RISE_LAST);
  assign fall_en = tick & (((state_q == JUMP) & ~hit_now & (action_q >= FALL_FIRST)) |
                           (state_q == HURT));
  assign summon_fire = tick & ~hit_now & (state_q == ATTACK) & (action_q == SUMMON_AT);
  assign face_d      = move_en ? key_left : face_q;
  assign busy_d      = (state_d == JUMP) | (state_d == ATTACK) | (state_d == HURT);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= IDLE;
      action_q      <= '0;
      face_q        <= (FACE_INIT != 0);
      hit_pending_q <= 1'b0;
      summon_q      <= 1'b0;
      ball_face_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      summon_q <= 1'b0;
      if (freeze) begin
        hit_pending_q <= 1'b0;
      end else if (frame_tick) begin
        hit_pending_q <= 1'b0;
        state_q       <= state_d;
        action_q      <= action_d;
        face_q        <= face_d;
        busy_q        <= busy_d;
        summon_q      <= summon_fire;
        if (summon_fire) begin
          ball_face_q <= face_q;
        end
      end else begin
        hit_pending_q <= hit_pending_q | hit;
      end
    end
  end

  player_motion #(
    .X_INIT   (X_INIT),
    .X_MIN    (X_MIN),
    .X_MAX    (X_MAX),
    .GROUND_Y (GROUND_Y),
    .WALK_STEP(WALK_STEP),
    .JUMP_STEP(JUMP_STEP)
  ) u_motion (
    .clk      (Clk),
    .srst     (Reset),
    .step_en_i(move_en),
    .left_i   (key_left),
    .rise_en_i(rise_en),
    .fall_en_i(fall_en),
    .x_o      (player_x),
    .y_o      (player_y)
  );

  assign player_action = action_q;
  assign face          = face_q;
  assign summon_ball   = summon_q;
  assign ball_face     = ball_face_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_player_action_fsm.sv
// Directed bench for player_action_fsm with hand-computed frame/position expectations.
module tb_player_action_fsm;

  logic       Clk = 1'b0;
  logic       Reset, frame_tick, key_left, key_right, key_jump, key_attack, hit, freeze;
  logic [8:0] player_action;
  logic       face, summon_ball, ball_face, busy;
  logic [9:0] player_x, player_y;

  int n_checks = 0;
  int n_errors = 0;
  int summon_cnt = 0;
  int cnt0;
  int exp_y;

  player_action_fsm dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_tick   (frame_tick),
    .key_left     (key_left),
    .key_right    (key_right),
    .key_jump     (key_jump),
    .key_attack   (key_attack),
    .hit          (hit),
    .freeze       (freeze),
    .player_action(player_action),
    .face         (face),
    .player_x     (player_x),
    .player_y     (player_y),
    .summon_ball  (summon_ball),
    .ball_face    (ball_face),
    .busy         (busy)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) if (summon_ball === 1'b1) summon_cnt++;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // One frame tick with an optional coincident hit; outputs are settled at return.
  task automatic do_tick(input logic h);
    @(negedge Clk);
    frame_tick = 1'b1;
    hit        = h;
    @(negedge Clk);
    frame_tick = 1'b0;
    hit        = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; frame_tick = 0; key_left = 0; key_right = 0;
    key_jump = 0; key_attack = 0; hit = 0; freeze = 0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    check_eq("rst_action", int'(player_action), 0);
    check_eq("rst_x", int'(player_x), 100);
    check_eq("rst_y", int'(player_y), 300);
    check_eq("rst_face", int'(face), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_summon", int'(summon_ball), 0);
    check_eq("rst_ball_face", int'(ball_face), 0);

    // Walk right for 30 ticks: 0..23 then 0..5, x 100 -> 160.
    key_right = 1;
    for (int i = 0; i < 30; i++) begin
      do_tick(0);
      check_eq($sformatf("walk_action[%0d]", i), int'(player_action), (i < 24) ? i : i - 24);
    end
    check_eq("walk_x", int'(player_x), 160);
    check_eq("walk_face", int'(face), 0);
    check_eq("walk_busy", int'(busy), 0);
    key_right = 0;
    do_tick(0);
    check_eq("walk_release_action", int'(player_action), 0);
    check_eq("walk_release_x", int'(player_x), 160);

    // Jump: 24..89, peak y 234 at 46..67, back to 300.
    key_jump = 1;
    do_tick(0);
    key_jump = 0;
    check_eq("jump_entry_action", int'(player_action), 24);
    check_eq("jump_entry_busy", int'(busy), 1);
    check_eq("jump_entry_y", int'(player_y), 300);
    exp_y = 300;
    for (int a = 24; a < 89; a++) begin
      do_tick(0);
      if (a <= 45) exp_y -= 3;
      else if (a >= 68) exp_y += 3;
      check_eq($sformatf("jump_action[%0d]", a + 1), int'(player_action), a + 1);
      if (a + 1 == 46 || a + 1 == 67 || a + 1 == 89)
        check_eq($sformatf("jump_y@%0d", a + 1), int'(player_y), exp_y);
    end
    check_eq("jump_peak_model", exp_y, 297);
    do_tick(0);
    check_eq("jump_done_action", int'(player_action), 0);
    check_eq("jump_done_y", int'(player_y), 300);
    check_eq("jump_done_busy", int'(busy), 0);

    // Turn left one step, then attack; summon fires once with ball_face = 1.
    key_left = 1;
    do_tick(0);
    key_left = 0;
    check_eq("turn_x", int'(player_x), 158);
    check_eq("turn_face", int'(face), 1);
    key_attack = 1;
    do_tick(0);
    key_attack = 0;
    check_eq("atk_entry_action", int'(player_action), 90);
    check_eq("atk_entry_x", int'(player_x), 158);
    cnt0 = summon_cnt;
    repeat (59) do_tick(0);
    check_eq("atk_at_149", int'(player_action), 149);
    check_eq("atk_no_early_summon", summon_cnt, cnt0);
    do_tick(0);
    check_eq("atk_150_action", int'(player_action), 150);
    check_eq("atk_summon_high", int'(summon_ball), 1);
    check_eq("atk_ball_face", int'(ball_face), 1);
    @(negedge Clk);
    check_eq("atk_summon_low", int'(summon_ball), 0);
    repeat (35) do_tick(0);
    check_eq("atk_at_185", int'(player_action), 185);
    do_tick(0);
    check_eq("atk_done_action", int'(player_action), 0);
    check_eq("atk_done_busy", int'(busy), 0);
    check_eq("atk_summon_count", summon_cnt, cnt0 + 1);

    // Hit at height 30 mid-jump, arriving between ticks.
    key_jump = 1;
    do_tick(0);
    key_jump = 0;
    repeat (10) do_tick(0);
    check_eq("hurt_pre_action", int'(player_action), 34);
    check_eq("hurt_pre_y", int'(player_y), 270);
    @(negedge Clk); hit = 1;
    @(negedge Clk); hit = 0;
    do_tick(0);
    check_eq("hurt_entry_action", int'(player_action), 186);
    check_eq("hurt_entry_y", int'(player_y), 270);
    for (int k = 1; k <= 23; k++) begin
      do_tick(0);
      if (k == 9) check_eq("hurt_y_k9", int'(player_y), 297);
      if (k == 10) check_eq("hurt_y_k10", int'(player_y), 300);
    end
    check_eq("hurt_at_209", int'(player_action), 209);
    do_tick(0);
    check_eq("hurt_done_action", int'(player_action), 0);
    check_eq("hurt_done_busy", int'(busy), 0);

    // Left clamp: walk 158 -> 4, then five more ticks land on and hold 0.
    key_left = 1;
    repeat (77) do_tick(0);
    check_eq("clamp_x4", int'(player_x), 4);
    check_eq("clamp_action4", int'(player_action), 4);
    for (int i = 0; i < 5; i++) begin
      do_tick(0);
      check_eq($sformatf("clamp_x[%0d]", i), int'(player_x), (i == 0) ? 2 : 0);
    end
    check_eq("clamp_face", int'(face), 1);
    check_eq("clamp_action9", int'(player_action), 9);
    key_right = 1;
    do_tick(0);
    check_eq("both_keys_action", int'(player_action), 0);
    check_eq("both_keys_x", int'(player_x), 0);
    check_eq("both_keys_face", int'(face), 1);
    key_left = 0; key_right = 0;

    // Freeze at attack 120 with hits: nothing moves, no HURT afterwards.
    key_attack = 1;
    do_tick(0);
    key_attack = 0;
    repeat (30) do_tick(0);
    check_eq("frz_pre_action", int'(player_action), 120);
    cnt0 = summon_cnt;
    freeze = 1;
    @(negedge Clk); hit = 1;
    @(negedge Clk); hit = 0;
    do_tick(1);
    repeat (4) do_tick(0);
    check_eq("frz_action", int'(player_action), 120);
    check_eq("frz_busy", int'(busy), 1);
    check_eq("frz_x", int'(player_x), 0);
    check_eq("frz_no_summon", summon_cnt, cnt0);
    freeze = 0;
    do_tick(0);
    check_eq("frz_resume_action", int'(player_action), 121);
    repeat (64) do_tick(0);
    check_eq("frz_at_185", int'(player_action), 185);
    do_tick(0);
    check_eq("frz_done_action", int'(player_action), 0);
    check_eq("frz_summon_count", summon_cnt, cnt0 + 1);

    // Hit on the tick cycle itself, then a HURT restart, then reset mid-HURT.
    do_tick(1);
    check_eq("cohit_action", int'(player_action), 186);
    check_eq("cohit_busy", int'(busy), 1);
    repeat (4) do_tick(0);
    check_eq("cohit_190", int'(player_action), 190);
    do_tick(1);
    check_eq("restart_action", int'(player_action), 186);
    do_tick(0);
    check_eq("restart_next", int'(player_action), 187);
    @(negedge Clk); Reset = 1;
    @(negedge Clk); Reset = 0;
    check_eq("midrst_action", int'(player_action), 0);
    check_eq("midrst_x", int'(player_x), 100);
    check_eq("midrst_face", int'(face), 0);
    check_eq("midrst_busy", int'(busy), 0);
    check_eq("midrst_y", int'(player_y), 300);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
